// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width, ALU select encoding, and the
// control half of the ID/EX pipeline slot.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD      = 4'b0000;
  localparam logic [3:0] ALU_SUB      = 4'b1000;
  localparam logic [3:0] ALU_AND      = 4'b0111;
  localparam logic [3:0] ALU_OR       = 4'b0110;
  localparam logic [3:0] ALU_XOR      = 4'b0100;
  localparam logic [3:0] ALU_SLT      = 4'b0010;
  localparam logic [3:0] ALU_SLTU     = 4'b0011;
  localparam logic [3:0] ALU_SLL      = 4'b0001;
  localparam logic [3:0] ALU_SRL      = 4'b0101;
  localparam logic [3:0] ALU_SRA      = 4'b1101;
  localparam logic [3:0] ALU_B_ASSIGN = 4'b1111;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       a_is_pc;
    logic       b_is_imm;
    logic [3:0] alu_select;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_ctl_t;

  localparam ex_ctl_t CTL_BUBBLE = '{
    valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
    a_is_pc: 1'b0, b_is_imm: 1'b0, alu_select: ALU_ADD,
    rd: 5'd0, rs1: 5'd0, rs2: 5'd0
  };

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass select: MEM result, then WB result, then the stored operand.
// Purely combinational, no backpressure; register x0 is never bypassed.
module fwd_mux #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [4:0]      idx,
  input  logic [XLEN-1:0] stored_dat,
  input  logic            mem_en,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_dat,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_dat,
  output logic [XLEN-1:0] fwd_dat
);

  always_comb begin
    fwd_dat = stored_dat;
    if (idx != 5'd0) begin
      if (mem_en && (mem_rd == idx))
        fwd_dat = mem_dat;
      else if (wb_en && (wb_rd == idx))
        fwd_dat = wb_dat;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with MEM/WB bypass and load-use bubble; operands valid 1 cycle after decode.
// stall_i freezes the slot, flush_i kills it, load_use_stall asks decode to hold.
module id_ex_stage #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_select,
  input  logic            id_a_is_pc,
  input  logic            id_b_is_imm,
  input  logic [4:0]      id_rd,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            mem_fwd_en,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_select,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_stall
);
  import riscv_pkg::*;

  ex_ctl_t         ctl_q, ctl_d;
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q;
  logic [XLEN-1:0] rs1_wt, rs2_wt;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  assign load_use_stall = ctl_q.valid && ctl_q.mem_read && (ctl_q.rd != 5'd0) && id_valid &&
                          ((ctl_q.rd == id_rs1) || (ctl_q.rd == id_rs2));

  always_comb begin
    ctl_d            = CTL_BUBBLE;
    ctl_d.valid      = id_valid;
    ctl_d.reg_write  = id_reg_write;
    ctl_d.mem_read   = id_mem_read;
    ctl_d.mem_write  = id_mem_write;
    ctl_d.a_is_pc    = id_a_is_pc;
    ctl_d.b_is_imm   = id_b_is_imm;
    ctl_d.alu_select = id_alu_select;
    ctl_d.rd         = id_rd;
    ctl_d.rs1        = id_rs1;
    ctl_d.rs2        = id_rs2;
  end

  // The register file write lands in the same edge we capture, so bypass it here.
  assign rs1_wt = (wb_en && (wb_rd != 5'd0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
  assign rs2_wt = (wb_en && (wb_rd != 5'd0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= CTL_BUBBLE;
      pc_q  <= '0;
      imm_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (flush_i || (!stall_i && load_use_stall)) begin
      ctl_q <= CTL_BUBBLE;
      pc_q  <= '0;
      imm_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (!stall_i) begin
      ctl_q <= ctl_d;
      pc_q  <= id_pc;
      imm_q <= id_imm;
      rs1_q <= rs1_wt;
      rs2_q <= rs2_wt;
    end
  end

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .idx(ctl_q.rs1), .stored_dat(rs1_q),
    .mem_en(mem_fwd_en), .mem_rd(mem_fwd_rd), .mem_dat(mem_fwd_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_dat(wb_data),
    .fwd_dat(rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .idx(ctl_q.rs2), .stored_dat(rs2_q),
    .mem_en(mem_fwd_en), .mem_rd(mem_fwd_rd), .mem_dat(mem_fwd_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_dat(wb_data),
    .fwd_dat(rs2_fwd)
  );

  assign alu_a         = ctl_q.a_is_pc  ? pc_q  : rs1_fwd;
  assign alu_b         = ctl_q.b_is_imm ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign alu_select    = ctl_q.alu_select;
  assign ex_valid      = ctl_q.valid;
  assign ex_reg_write  = ctl_q.reg_write;
  assign ex_mem_read   = ctl_q.mem_read;
  assign ex_mem_write  = ctl_q.mem_write;
  assign ex_rd         = ctl_q.rd;
  assign ex_pc         = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding, load-use, write-through,
// stall/flush priority and operand selects, each against hand-computed values.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]  id_alu_select;
  logic        id_a_is_pc, id_b_is_imm;
  logic [4:0]  id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        stall_i, flush_i;
  logic        mem_fwd_en;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_select;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc, ex_store_data;
  logic        load_use_stall;

  int checks = 0;
  int passed = 0;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_select(id_alu_select), .id_a_is_pc(id_a_is_pc), .id_b_is_imm(id_b_is_imm),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .stall_i(stall_i), .flush_i(flush_i),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic id_drv(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [3:0] sel, input logic apc,
                        input logic bimm, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic mw);
    id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_select = sel;
    id_a_is_pc = apc; id_b_is_imm = bimm; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic byp(input logic me, input logic [4:0] mrd, input logic [31:0] md,
                     input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    mem_fwd_en = me; mem_fwd_rd = mrd; mem_fwd_data = md;
    wb_en = we; wb_rd = wrd; wb_data = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with random garbage on every input
    rst_n = 1'b0;
    id_drv($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    byp($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    stall_i = $urandom; flush_i = $urandom;
    #23;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_reg_write", ex_reg_write, 0);
    chk("rst_mem_read", ex_mem_read, 0);
    chk("rst_mem_write", ex_mem_write, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_alu_select", alu_select, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_store_data", ex_store_data, 0);
    chk("rst_load_use", load_use_stall, 0);

    stall_i = 0; flush_i = 0;
    byp(0, 0, 0, 0, 0, 0);
    id_drv(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    tick;
    rst_n = 1'b1;

    // Basic capture: add x3, x1, x2
    id_drv(1, 32'h10, 1, 2, 5, 7, 0, 4'b0000, 0, 0, 3, 1, 0, 0);
    tick;
    chk("cap_alu_a", alu_a, 5);
    chk("cap_alu_b", alu_b, 7);
    chk("cap_alu_select", alu_select, 4'b0000);
    chk("cap_ex_valid", ex_valid, 1);
    chk("cap_ex_rd", ex_rd, 3);
    chk("cap_reg_write", ex_reg_write, 1);
    chk("cap_ex_pc", ex_pc, 32'h10);

    // MEM beats WB for rs1=3; then WB alone
    id_drv(1, 32'h14, 3, 0, 0, 0, 0, 4'b1000, 0, 0, 6, 1, 0, 0);
    tick;
    byp(1, 3, 32'h1234, 1, 3, 32'h9999);
    #1;
    chk("fwd_mem_prio", alu_a, 32'h1234);
    chk("fwd_alu_select", alu_select, 4'b1000);
    byp(0, 3, 32'h1234, 1, 3, 32'h9999);
    #1;
    chk("fwd_wb", alu_a, 32'h9999);
    byp(1, 0, 32'h1234, 1, 0, 32'h9999);
    id_drv(1, 32'h18, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 6, 1, 0, 0);
    tick;
    chk("fwd_x0_a", alu_a, 0);
    chk("fwd_x0_b", alu_b, 0);
    byp(0, 0, 0, 0, 0, 0);

    // Load-use: lw x5, 4(x1) then add x7, x6, x5
    id_drv(1, 32'h20, 1, 0, 32'h40, 0, 4, 4'b0000, 0, 1, 5, 1, 1, 0);
    tick;
    chk("lw_mem_read", ex_mem_read, 1);
    id_drv(1, 32'h24, 6, 5, 10, 32'hDEAD, 0, 4'b0000, 0, 0, 7, 1, 0, 0);
    #1;
    chk("lu_stall", load_use_stall, 1);
    tick;
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_rd", ex_rd, 0);
    chk("lu_stall_clear", load_use_stall, 0);
    byp(1, 5, 32'h777, 0, 0, 0);
    tick;
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_b", alu_b, 32'h777);
    chk("lu_add_a", alu_a, 10);
    chk("lu_store_data", ex_store_data, 32'h777);
    byp(0, 0, 0, 0, 0, 0);

    // Write-through of WB into captured operands
    id_drv(1, 32'h28, 4, 4, 1, 2, 0, 4'b0110, 0, 0, 8, 1, 0, 0);
    byp(0, 0, 0, 1, 4, 32'hAB);
    tick;
    byp(0, 0, 0, 0, 0, 0);
    #1;
    chk("wt_rs1", alu_a, 32'hAB);
    chk("wt_rs2", alu_b, 32'hAB);

    // Flush beats stall
    flush_i = 1; stall_i = 1;
    tick;
    flush_i = 0; stall_i = 0;
    chk("flush_valid", ex_valid, 0);
    chk("flush_rd", ex_rd, 0);
    chk("flush_reg_write", ex_reg_write, 0);

    // Capture a load, then hold it for 3 cycles against a dependent decode
    id_drv(1, 32'h200, 1, 2, 32'h11, 32'h22, 0, 4'b1000, 0, 0, 9, 1, 1, 0);
    tick;
    stall_i = 1;
    id_drv(1, 32'h300, 9, 3, 32'h55, 32'h66, 0, 4'b0111, 0, 0, 10, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hold_valid", ex_valid, 1);
      chk("hold_pc", ex_pc, 32'h200);
      chk("hold_rd", ex_rd, 9);
      chk("hold_sel", alu_select, 4'b1000);
      chk("hold_a", alu_a, 32'h11);
      chk("hold_b", alu_b, 32'h22);
      chk("hold_mem_write", ex_mem_write, 0);
      chk("hold_lu_stall", load_use_stall, 1);
    end
    stall_i = 0;
    tick;
    chk("release_bubble", ex_valid, 0);

    // Operand selects: PC and immediate
    id_drv(1, 32'h100, 1, 2, 32'h55, 32'h66, 32'hFFFFFFFC, 4'b0000, 1, 1, 11, 1, 0, 1);
    tick;
    chk("sel_a_pc", alu_a, 32'h100);
    chk("sel_b_imm", alu_b, 32'hFFFFFFFC);
    chk("sel_store", ex_store_data, 32'h66);
    chk("sel_mem_write", ex_mem_write, 1);

    // Asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_a", alu_a, 0);
    chk("arst_b", alu_b, 0);
    chk("arst_mem_write", ex_mem_write, 0);
    tick;
    rst_n = 1'b1;
    id_valid = 0;
    tick;
    chk("post_rst_valid", ex_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
